// File: rtl/interfpga_pkg.sv
// Shared definitions for the 4-bit inter-FPGA nibble link (transmit and receive sides).
package interfpga_pkg;
  localparam int NIBBLE_W     = 4;
  localparam int BURST_CYCLES = 4;
  localparam int MIN_GAP      = 1;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    LO0  = 3'd1,
    LO1  = 3'd2,
    HI0  = 3'd3,
    HI1  = 3'd4,
    GAP  = 3'd5
  } link_state_t;
endpackage

// File: rtl/interfpga_tx_fifo.sv
// Synchronous byte FIFO for the link transmitter; combinational read of the head entry.
module interfpga_tx_fifo #(
  parameter int FIFO_DEPTH = 8,
  parameter int DATA_W     = 8
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          push,
  input  logic [DATA_W-1:0]             push_data,
  input  logic                          pop,
  output logic [DATA_W-1:0]             pop_data,
  output logic                          full,
  output logic                          empty,
  output logic [$clog2(FIFO_DEPTH):0]   level
);
  localparam int PW = $clog2(FIFO_DEPTH);

  logic [DATA_W-1:0] mem [FIFO_DEPTH];
  logic [PW-1:0]     wr_ptr;
  logic [PW-1:0]     rd_ptr;
  logic              push_ok;
  logic              pop_ok;

  assign full     = (level == (PW+1)'(FIFO_DEPTH));
  assign empty    = (level == '0);
  // No pass-through when full: a push is refused even if a pop happens this cycle.
  assign push_ok  = push & ~full;
  assign pop_ok   = pop & ~empty;
  assign pop_data = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + PW'(1);
      if (pop_ok)  rd_ptr <= rd_ptr + PW'(1);
      case ({push_ok, pop_ok})
        2'b10:   level <= level + (PW+1)'(1);
        2'b01:   level <= level - (PW+1)'(1);
        default: level <= level;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= push_data;
  end
endmodule

// File: rtl/interfpga_link_tx.sv
// Buffered nibble-link transmitter: FIFO, burst FSM, hold register and gap counter.
// Optional tx_count statistics output when INTERFPGA_TX_STATS_EN is defined.
module interfpga_link_tx
  import interfpga_pkg::*;
#(
  parameter int FIFO_DEPTH = 8,
  parameter int GAP_CYCLES = 1
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [7:0]                    in_data,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic                          hold,
  output logic [NIBBLE_W-1:0]           data_o,
  output logic                          ctrl_o,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   level
`ifdef INTERFPGA_TX_STATS_EN
  ,
  output logic [15:0]                   tx_count
`endif
);
  localparam int GAP_EFF = (GAP_CYCLES < MIN_GAP) ? MIN_GAP : GAP_CYCLES;
  localparam int GW      = (GAP_EFF > 1) ? $clog2(GAP_EFF) : 1;

  link_state_t   state_q, state_d;
  logic [GW-1:0] gap_cnt_q, gap_cnt_d;
  logic [7:0]    byte_q, byte_d;
  logic [7:0]    fifo_data;
  logic          fifo_full;
  logic          fifo_empty;
  logic          pop;

  function automatic logic [NIBBLE_W:0] link_word(link_state_t s, logic [7:0] b);
    case (s)
      LO0, LO1: return {1'b1, b[3:0]};
      HI0, HI1: return {1'b1, b[7:4]};
      default:  return '0;
    endcase
  endfunction

  interfpga_tx_fifo #(
    .FIFO_DEPTH (FIFO_DEPTH),
    .DATA_W     (8)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (in_valid),
    .push_data (in_data),
    .pop       (pop),
    .pop_data  (fifo_data),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .level     (level)
  );

  assign in_ready = ~fifo_full;
  assign busy     = ~fifo_empty | (state_q != IDLE);

  always_comb begin
    state_d   = state_q;
    gap_cnt_d = gap_cnt_q;
    byte_d    = byte_q;
    pop       = 1'b0;
    case (state_q)
      IDLE: begin
        // hold only gates the start of a burst; a burst in flight always completes.
        if (!fifo_empty && !hold) begin
          state_d = LO0;
          pop     = 1'b1;
          byte_d  = fifo_data;
        end
      end
      LO0: state_d = LO1;
      LO1: state_d = HI0;
      HI0: state_d = HI1;
      HI1: begin
        state_d   = GAP;
        gap_cnt_d = '0;
      end
      GAP: begin
        if (gap_cnt_q == GW'(GAP_EFF - 1)) state_d = IDLE;
        else                               gap_cnt_d = gap_cnt_q + GW'(1);
      end
      default: state_d = IDLE;
    endcase
  end

  // Link outputs are registered from the next state so ctrl_o rises on the popping edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      gap_cnt_q <= '0;
      ctrl_o    <= 1'b0;
      data_o    <= '0;
    end else begin
      state_q          <= state_d;
      gap_cnt_q        <= gap_cnt_d;
      {ctrl_o, data_o} <= link_word(state_d, byte_d);
    end
  end

  always_ff @(posedge clk) begin
    byte_q <= byte_d;
  end

`ifdef INTERFPGA_TX_STATS_EN
  always_ff @(posedge clk) begin
    if (reset)    tx_count <= '0;
    else if (pop) tx_count <= tx_count + 16'd1;
  end
`endif
endmodule

// File: tb/tb_interfpga_link_tx.sv
// Scoreboard bench for interfpga_link_tx: byte queue model plus burst/occupancy monitor.
module tb_interfpga_link_tx;
  localparam int DEPTH  = 8;
  localparam int GAP    = 1;
  localparam int PERIOD = 5 + GAP;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] in_data;
  logic       in_valid;
  logic       in_ready;
  logic       hold;
  logic [3:0] data_o;
  logic       ctrl_o;
  logic       busy;
  logic [3:0] level;
`ifdef INTERFPGA_TX_STATS_EN
  logic [15:0] tx_count;
`endif

  interfpga_link_tx #(.FIFO_DEPTH(DEPTH), .GAP_CYCLES(GAP)) dut (
    .clk      (clk),
    .reset    (reset),
    .in_data  (in_data),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .hold     (hold),
    .data_o   (data_o),
    .ctrl_o   (ctrl_o),
    .busy     (busy),
    .level    (level)
`ifdef INTERFPGA_TX_STATS_EN
    ,
    .tx_count (tx_count)
`endif
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  task automatic check(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference model: bytes accepted but not yet seen on the wire, in acceptance order.
  logic [7:0] exp_q[$];
  int         rise_q[$];
  int         accepted = 0;
  int         starts = 0;
  int         nib_cnt = 0;
  int         low_cnt = 0;
  int         cyc = 0;
  bit         prev_ctrl = 0;
  bit         prev_hold = 0;
  bit         seen_burst = 0;
  logic [3:0] nibs[4];

  always @(negedge clk) begin
    cyc++;
    if (reset) begin
      exp_q.delete();
      accepted   = 0;
      starts     = 0;
      nib_cnt    = 0;
      low_cnt    = 0;
      prev_ctrl  = 0;
      prev_hold  = 0;
      seen_burst = 0;
    end else begin
      if (ctrl_o && !prev_ctrl) begin
        starts++;
        rise_q.push_back(cyc);
        check("start while hold high", int'(prev_hold), 0);
        if (seen_burst) check("inter-burst gap", int'(low_cnt >= GAP + 1), 1);
        nib_cnt = 0;
        low_cnt = 0;
      end
      if (ctrl_o) begin
        if (nib_cnt < 4) nibs[nib_cnt] = data_o;
        nib_cnt++;
      end else begin
        check("data_o idle", data_o, 0);
        low_cnt++;
        if (prev_ctrl) begin
          logic [7:0] e;
          seen_burst = 1;
          check("burst length", nib_cnt, 4);
          if (exp_q.size() == 0) begin
            check("unexpected burst", 1, 0);
          end else begin
            e = exp_q.pop_front();
            check("nibble lo0", nibs[0], e[3:0]);
            check("nibble lo1", nibs[1], e[3:0]);
            check("nibble hi0", nibs[2], e[7:4]);
            check("nibble hi1", nibs[3], e[7:4]);
          end
        end
      end
      check("level", level, accepted - starts);
      check("in_ready", in_ready, int'((accepted - starts) < DEPTH));
      if (in_valid && in_ready) begin
        exp_q.push_back(in_data);
        accepted++;
      end
      prev_ctrl = ctrl_o;
      prev_hold = hold;
    end
  end

  task automatic at_neg();
    @(negedge clk);
    #1;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Entered and left at 1ns after a rising edge; leaves in_valid high.
  task automatic push(input logic [7:0] b, output int waited);
    in_valid = 1'b1;
    in_data  = b;
    waited   = 0;
    for (int i = 0; i < 400; i++) begin
      at_neg();
      if (in_ready) begin
        step();
        return;
      end
      waited++;
      step();
    end
    check("push timeout", 0, 1);
  endtask

  task automatic drain(input int budget);
    for (int i = 0; i < budget; i++) begin
      step();
      if (exp_q.size() == 0 && !busy && !ctrl_o) return;
    end
    check("drain timeout", 0, 1);
  endtask

  task automatic wait_nib(input int n);
    for (int i = 0; i < 200; i++) begin
      at_neg();
      if (ctrl_o && nib_cnt == n) return;
    end
    check("burst wait timeout", 0, 1);
  endtask

  initial begin
    int w;
    reset    = 1'b1;
    in_valid = 1'b0;
    in_data  = 8'h00;
    hold     = 1'b0;
    repeat (3) step();
    reset = 1'b0;
    at_neg();
    check("reset ctrl_o", ctrl_o, 0);
    check("reset data_o", data_o, 0);
    check("reset in_ready", in_ready, 1);
    check("reset busy", busy, 0);
    check("reset level", level, 0);
`ifdef INTERFPGA_TX_STATS_EN
    check("reset tx_count", tx_count, 0);
`endif
    step();

    // Single byte: latency, nibble order, busy after gap.
    push(8'hA5, w);
    in_valid = 1'b0;
    at_neg();
    check("ctrl_o before LO0", ctrl_o, 0);
    at_neg();
    check("ctrl_o at LO0", ctrl_o, 1);
    check("data_o at LO0", data_o, 4'h5);
    repeat (2) at_neg();
    check("data_o at HI0", data_o, 4'hA);
    at_neg();
    at_neg();
    check("ctrl_o in gap", ctrl_o, 0);
    check("busy in gap", busy, 1);
    repeat (GAP) at_neg();
    check("busy after gap", busy, 0);
    step();
    drain(100);

    // Back-to-back stream: all accepted immediately, bursts PERIOD apart.
    rise_q.delete();
    for (int b = 0; b < 8; b++) begin
      push(8'(b), w);
      check("stream accept wait", w, 0);
    end
    in_valid = 1'b0;
    drain(200);
    check("stream burst count", rise_q.size(), 8);
    if (rise_q.size() == 8)
      for (int i = 1; i < 8; i++) check("stream period", rise_q[i] - rise_q[i-1], PERIOD);

    // Fill under hold, refused push, in_ready returns after first pop.
    hold = 1'b1;
    for (int b = 0; b < DEPTH; b++) push(8'($urandom), w);
    in_data = 8'hEE;
    at_neg();
    check("full level", level, DEPTH);
    check("full in_ready", in_ready, 0);
    step();
    at_neg();
    check("level after refused push", level, DEPTH);
    step();
    in_valid = 1'b0;
    hold     = 1'b0;
    at_neg();
    check("in_ready before pop", in_ready, 0);
    at_neg();
    check("in_ready after pop", in_ready, 1);
    check("ctrl_o after release", ctrl_o, 1);
    step();
    drain(300);

    // hold raised during HI0: current burst completes, nothing new starts.
    push(8'h3C, w);
    push(8'hC3, w);
    push(8'h96, w);
    in_valid = 1'b0;
    wait_nib(2);
    step();
    hold = 1'b1;
    begin
      int s0;
      s0 = starts;
      repeat (20) at_neg();
      check("starts under hold", starts - s0, 0);
      check("level under hold", level, 2);
    end
    step();
    hold = 1'b0;
    drain(200);

    // Reset during LO1 with three bytes queued.
    hold = 1'b1;
    for (int b = 0; b < 4; b++) push(8'(8'h50 + b), w);
    in_valid = 1'b0;
    hold     = 1'b0;
    wait_nib(1);
    step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    at_neg();
    check("post-reset ctrl_o", ctrl_o, 0);
    check("post-reset data_o", data_o, 0);
    check("post-reset level", level, 0);
    check("post-reset in_ready", in_ready, 1);
    repeat (30) at_neg();
    check("bursts after reset", starts, 0);
    step();

`ifdef INTERFPGA_TX_STATS_EN
    for (int b = 0; b < 5; b++) push(8'($urandom), w);
    in_valid = 1'b0;
    drain(200);
    check("tx_count after 5", tx_count, 5);
    force dut.tx_count = 16'hFFFF;
    step();
    release dut.tx_count;
    push(8'h77, w);
    in_valid = 1'b0;
    drain(100);
    check("tx_count wrap", tx_count, 0);
`endif

    // Randomised traffic with random hold toggling.
    for (int i = 0; i < 600; i++) begin
      in_valid = ($urandom_range(3) != 0);
      in_data  = 8'($urandom);
      if ($urandom_range(15) == 0) hold = ~hold;
      step();
    end
    in_valid = 1'b0;
    hold     = 1'b0;
    drain(400);
    check("random leftover bytes", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end
endmodule
